fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of the opcode decoder / control unit in the MIPS-style core.
- Owns the PC and issues reads on the instruction-memory bus (read/waitrequest handshake).
- Presents one instruction at a time to decode with a valid/ready handshake.
- Applies branch/jump redirects from decode with MIPS single-delay-slot semantics, and halts on a fetch from HALT_ADDR.

---
 rtl/fetch_unit.sv | 91 +++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads instruction memory and hands one
// instruction at a time to decode, honouring single-delay-slot redirects.
module fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_address,
    output logic        imem_read,
    input  logic        imem_waitrequest,
    input  logic [31:0] imem_readdata,
    output logic [31:0] instr,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] pc,
    output logic [31:0] link_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        halted
);

    typedef enum logic [1:0] {BOOT, FETCH, VALID, HALTED} state_t;

    state_t      state, state_nxt;
    logic [31:0] pc_nxt, instr_nxt;
    logic [31:0] pending_target, pending_target_nxt;
    logic        delay_pending, delay_pending_nxt;
    logic [31:0] seq_next;

    // Handshakes: a memory read completes on a cycle with imem_read=1 and
    // imem_waitrequest=0; an instruction transfers to decode on a cycle with
    // instr_valid=1 and instr_ready=1. Redirect inputs matter only on that cycle.

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= BOOT;
            pc             <= RESET_VECTOR;
            instr          <= 32'd0;
            delay_pending  <= 1'b0;
            pending_target <= 32'd0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            instr          <= instr_nxt;
            delay_pending  <= delay_pending_nxt;
            pending_target <= pending_target_nxt;
        end
    end

    always_comb begin
        state_nxt          = state;
        pc_nxt             = pc;
        instr_nxt          = instr;
        delay_pending_nxt  = delay_pending;
        pending_target_nxt = pending_target;
        // A pending branch target takes priority over sequential flow.
        seq_next           = delay_pending ? pending_target : pc + 32'd4;
        case (state)
            BOOT: state_nxt = FETCH;
            FETCH: begin
                if (!imem_waitrequest) begin
                    instr_nxt = imem_readdata;
                    state_nxt = VALID;
                end
            end
            VALID: begin
                if (instr_ready) begin
                    pc_nxt = seq_next;
                    if (delay_pending) begin
                        // Redirects from a delay-slot instruction are dropped.
                        delay_pending_nxt = 1'b0;
                    end else if (redirect_valid) begin
                        pending_target_nxt = {redirect_target[31:2], 2'b00};
                        delay_pending_nxt  = 1'b1;
                    end
                    state_nxt = (seq_next == HALT_ADDR) ? HALTED : FETCH;
                end
            end
            HALTED: state_nxt = HALTED;
            default: state_nxt = BOOT;
        endcase
    end

    assign imem_address = pc;
    assign imem_read    = (state == FETCH);
    assign instr_valid  = (state == VALID);
    assign halted       = (state == HALTED);
    assign link_pc      = pc + 32'd8;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: acts as instruction memory and decoder,
// predicting fetch order from the delay-slot rules.
module tb_fetch_unit;

  localparam logic [31:0] RV = 32'hBFC00000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_address;
  logic        imem_read;
  logic        imem_waitrequest = 1'b0;
  logic [31:0] imem_readdata = 32'd0;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] pc;
  logic [31:0] link_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        halted;

  int errors = 0;
  int checks = 0;

  // reference model: program-order view of the fetch stream
  logic [31:0] m_pc;
  logic        m_branch_waiting;
  logic [31:0] m_branch_dest;
  logic        m_halted;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n),
    .imem_address(imem_address), .imem_read(imem_read),
    .imem_waitrequest(imem_waitrequest), .imem_readdata(imem_readdata),
    .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .pc(pc), .link_pc(link_pc),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .halted(halted)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    m_pc = RV;
    m_branch_waiting = 1'b0;
    m_branch_dest = 32'd0;
    m_halted = 1'b0;
  endfunction

  // decode consumed the instruction at m_pc; work out what is fetched next
  function automatic void model_accept(input bit redir, input logic [31:0] tgt);
    logic [31:0] nxt;
    if (m_branch_waiting) begin
      nxt = m_branch_dest;
      m_branch_waiting = 1'b0;
    end else begin
      nxt = m_pc + 32'd4;
      if (redir) begin
        m_branch_dest = tgt & 32'hFFFFFFFC;
        m_branch_waiting = 1'b1;
      end
    end
    m_pc = nxt;
    m_halted = (nxt == 32'd0);
  endfunction

  // Called at a negedge with the DUT in its fetch phase; leaves at a negedge after accept.
  task automatic run_instr(input int waits, input int rdelay, input bit redir,
                           input logic [31:0] tgt, input logic [31:0] data);
    checks++; if (imem_read !== 1'b1) begin errors++; $display("FAIL fetch_read: got %b want 1", imem_read); end
    checks++; if (imem_address !== m_pc) begin errors++; $display("FAIL fetch_addr: got %h want %h", imem_address, m_pc); end
    for (int i = 0; i < waits; i++) begin
      imem_waitrequest = 1'b1;
      imem_readdata = $urandom;
      @(negedge clk);
      checks++; if (imem_read !== 1'b1 || imem_address !== m_pc) begin errors++; $display("FAIL stall_hold: got read=%b addr=%h want 1 %h", imem_read, imem_address, m_pc); end
      checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL stall_valid: got %b want 0", instr_valid); end
    end
    imem_waitrequest = 1'b0;
    imem_readdata = data;
    @(negedge clk);
    imem_waitrequest = 1'($urandom_range(0, 1));
    imem_readdata = $urandom;
    checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL valid_rise: got %b want 1", instr_valid); end
    checks++; if (instr !== data) begin errors++; $display("FAIL instr: got %h want %h", instr, data); end
    checks++; if (pc !== m_pc) begin errors++; $display("FAIL pc: got %h want %h", pc, m_pc); end
    checks++; if (link_pc !== m_pc + 32'd8) begin errors++; $display("FAIL link_pc: got %h want %h", link_pc, m_pc + 32'd8); end
    checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL valid_noread: got %b want 0", imem_read); end
    for (int i = 0; i < rdelay; i++) begin
      instr_ready = 1'b0;
      redirect_valid = 1'($urandom_range(0, 1));
      redirect_target = $urandom;
      @(negedge clk);
      imem_readdata = $urandom;
      checks++; if (instr_valid !== 1'b1 || instr !== data || pc !== m_pc) begin errors++; $display("FAIL hold: got v=%b i=%h pc=%h want 1 %h %h", instr_valid, instr, pc, data, m_pc); end
      checks++; if (imem_read !== 1'b0) begin errors++; $display("FAIL hold_noread: got %b want 0", imem_read); end
    end
    instr_ready = 1'b1;
    redirect_valid = redir;
    redirect_target = tgt;
    @(negedge clk);
    model_accept(redir, tgt);
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    imem_waitrequest = 1'b0;
    if (m_halted) begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (halted !== 1'b1 || imem_read !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt_state: got h=%b r=%b v=%b want 1 0 0", halted, imem_read, instr_valid); end
        checks++; if (pc !== 32'd0) begin errors++; $display("FAIL halt_pc: got %h want 0", pc); end
        imem_readdata = $urandom;
        instr_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
      instr_ready = 1'b0;
    end else begin
      checks++; if (halted !== 1'b0) begin errors++; $display("FAIL not_halted: got %b want 0", halted); end
    end
  endtask

  task automatic reset_and_boot();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (imem_read !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL reset_ctrl: got r=%b v=%b h=%b want 0 0 0", imem_read, instr_valid, halted); end
    checks++; if (imem_address !== RV || pc !== RV) begin errors++; $display("FAIL reset_pc: got addr=%h pc=%h want %h", imem_address, pc, RV); end
    checks++; if (link_pc !== 32'hBFC00008) begin errors++; $display("FAIL reset_link: got %h want bfc00008", link_pc); end
    checks++; if (instr !== 32'd0) begin errors++; $display("FAIL reset_instr: got %h want 0", instr); end
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
  endtask

  task automatic test_basic();
    run_instr(0, 0, 1'b0, 32'd0, 32'h8C010004);
  endtask

  task automatic test_stall();
    run_instr(3, 0, 1'b0, 32'd0, 32'h00221820);
  endtask

  task automatic test_ready_hold();
    run_instr(0, 4, 1'b0, 32'd0, 32'h20420001);
  endtask

  task automatic test_redirect();
    run_instr(0, 0, 1'b0, 32'd0, 32'h00000000);
    run_instr(1, 1, 1'b1, 32'hBFC00103, 32'h08000040);
    run_instr(0, 0, 1'b0, 32'd0, 32'h24010001);
    checks++; if (imem_address !== 32'hBFC00100) begin errors++; $display("FAIL redirect_target: got %h want bfc00100", imem_address); end
  endtask

  task automatic test_branch_in_delay();
    run_instr(0, 0, 1'b1, 32'hBFC00200, 32'h10000010);
    run_instr(0, 0, 1'b1, 32'hBFC00300, 32'h10000020);
    checks++; if (imem_address !== 32'hBFC00200) begin errors++; $display("FAIL delay_branch: got %h want bfc00200", imem_address); end
    run_instr(0, 0, 1'b0, 32'd0, 32'h3C01BFC0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit redir;
      logic [31:0] tgt;
      redir = ($urandom_range(0, 3) == 0);
      tgt = {16'hBFC0, 16'($urandom_range(16, 65535))};
      run_instr($urandom_range(0, 3), $urandom_range(0, 3), redir, tgt, $urandom);
    end
  endtask

  task automatic test_wrap_halt();
    if (!m_branch_waiting) run_instr(0, 0, 1'b0, 32'd0, $urandom);
    if (m_branch_waiting) run_instr(0, 0, 1'b0, 32'd0, $urandom);
    run_instr(0, 0, 1'b1, 32'hFFFFFFF9, $urandom);
    run_instr(0, 0, 1'b0, 32'd0, $urandom);
    run_instr(0, 0, 1'b0, 32'd0, $urandom);
    checks++; if (link_pc !== 32'd4 || imem_address !== 32'hFFFFFFFC) begin errors++; $display("FAIL wrap_link: got link=%h addr=%h want 4 fffffffc", link_pc, imem_address); end
    run_instr(0, 0, 1'b0, 32'd0, $urandom);
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL wrap_halt: got %b want 1", halted); end
  endtask

  task automatic test_halt_redirect();
    reset_and_boot();
    run_instr(0, 0, 1'b1, 32'h00000000, 32'h08000000);
    run_instr(0, 0, 1'b0, 32'd0, 32'h00000000);
    checks++; if (halted !== 1'b1 || imem_read !== 1'b0) begin errors++; $display("FAIL halt_redirect: got h=%b r=%b want 1 0", halted, imem_read); end
  endtask

  task automatic test_reset_mid_fetch();
    reset_and_boot();
    run_instr(0, 0, 1'b0, 32'd0, $urandom);
    imem_waitrequest = 1'b1;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if (imem_read !== 1'b0 || instr_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL midreset_ctrl: got r=%b v=%b h=%b want 0 0 0", imem_read, instr_valid, halted); end
    checks++; if (imem_address !== RV || link_pc !== 32'hBFC00008) begin errors++; $display("FAIL midreset_addr: got addr=%h link=%h want %h bfc00008", imem_address, link_pc, RV); end
    @(negedge clk);
    imem_waitrequest = 1'b0;
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    run_instr(1, 0, 1'b0, 32'd0, 32'h8C010004);
    run_instr(0, 0, 1'b0, 32'd0, $urandom);
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_stall();
    test_ready_hold();
    test_redirect();
    test_branch_in_delay();
    test_random();
    test_wrap_halt();
    test_halt_redirect();
    test_reset_mid_fetch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
